// File: rtl/seq_divider_if.sv
// Handshake and result bundle for seq_divider: operands in, quotient/remainder/flags out.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;
  logic             busy;

  // Requester side (kinematics sequencer / bench)
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow, busy
  );

  // Divider side
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow, busy
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring sequential divider, one quotient bit per clock, signed or unsigned.
// Optional macro DIV_SAT_EN: divide-by-zero saturates the quotient and zeroes the remainder.
module seq_divider #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SIGNED = 0
) (
  input logic          clk,
  input logic          reset,
  seq_divider_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;       // dividend magnitude, becomes quotient magnitude
  logic [WIDTH-1:0] b_q, b_d;       // divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             negq_q, negq_d; // quotient sign fix-up
  logic             negr_q, negr_d; // remainder / dividend sign
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             ovalid_q, ovalid_d;
  logic             iready_q, iready_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return (SIGNED != 0 && x[WIDTH-1]) ? -x : x;
  endfunction

  // Next-state, datapath step and final result formatting
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    quo_d    = quo_q;
    rmd_d    = rmd_q;
    ovalid_d = ovalid_q;

    shifted = {rem_q, a_q[WIDTH-1]};
    diff    = shifted - {1'b0, b_q};

    q_res = negq_q ? -a_q : a_q;
    r_res = negr_q ? -rem_q : rem_q;
    if (dz_q) begin
`ifdef DIV_SAT_EN
      if (SIGNED != 0) q_res = negr_q ? MIN_VAL : ~MIN_VAL;
      else             q_res = '1;
      r_res = '0;
`else
      // Operands never entered CALC, so a_q still holds |dividend|
      q_res = '1;
      r_res = negr_q ? -a_q : a_q;
`endif
    end

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && iready_q) begin
          a_d    = mag(bus.dividend);
          b_d    = mag(bus.divisor);
          rem_d  = '0;
          cnt_d  = CNT_INIT;
          negq_d = (SIGNED != 0) && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
          negr_d = (SIGNED != 0) && bus.dividend[WIDTH-1];
          dz_d   = (bus.divisor == '0);
          ovf_d  = (SIGNED != 0) && (bus.dividend == MIN_VAL) && (bus.divisor == '1);
          state_d = (bus.divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        a_d   = {a_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        if (!ovalid_q) begin
          ovalid_d = 1'b1;
          quo_d    = q_res;
          rmd_d    = r_res;
        end else if (bus.out_ready) begin
          ovalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    iready_d = (state_d == IDLE);
    busy_d   = (state_d != IDLE);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      quo_q    <= '0;
      rmd_q    <= '0;
      ovalid_q <= 1'b0;
      iready_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      quo_q    <= quo_d;
      rmd_q    <= rmd_d;
      ovalid_q <= ovalid_d;
      iready_q <= iready_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.in_ready    = iready_q;
  assign bus.out_valid   = ovalid_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rmd_q;
  assign bus.div_by_zero = dz_q;
  assign bus.overflow    = ovf_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: 16-bit unsigned, 16-bit signed and 8-bit unsigned instances.
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(16)) i0 ();
  seq_divider_if #(.WIDTH(16)) i1 ();
  seq_divider_if #(.WIDTH(8))  i2 ();

  seq_divider #(.WIDTH(16), .SIGNED(0)) u0 (.clk(clk), .reset(rst_n), .bus(i0));
  seq_divider #(.WIDTH(16), .SIGNED(1)) u1 (.clk(clk), .reset(rst_n), .bus(i1));
  seq_divider #(.WIDTH(8),  .SIGNED(0)) u2 (.clk(clk), .reset(rst_n), .bus(i2));

  int n_cmp = 0;
  int n_bad = 0;

  // Arithmetic reference: quotient/remainder/flags straight from the divider's rules
  function automatic void model(input int w, input bit sgn, input longint ua, input longint ub,
                                output longint q, output longint r, output bit dz, output bit ov);
    longint one, mask, minv, maxv, a, b;
    one  = 1;
    mask = (one << w) - 1;
    minv = -(one << (w - 1));
    maxv = (one << (w - 1)) - 1;
    a = ua & mask;
    b = ub & mask;
    if (sgn && a > maxv) a = a - (one << w);
    if (sgn && b > maxv) b = b - (one << w);
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      dz = 1'b1;
`ifdef DIV_SAT_EN
      q = sgn ? ((a < 0) ? minv : maxv) : mask;
      r = 0;
`else
      q = mask;
      r = a;
`endif
    end else if (sgn && a == minv && b == -1) begin
      q  = minv;
      r  = 0;
      ov = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
    end
    q = q & mask;
    r = r & mask;
  endfunction

  task automatic drv(input int sel, input bit v, input longint a, input longint b);
    case (sel)
      0: begin i0.in_valid = v; i0.dividend = 16'(a); i0.divisor = 16'(b); end
      1: begin i1.in_valid = v; i1.dividend = 16'(a); i1.divisor = 16'(b); end
      default: begin i2.in_valid = v; i2.dividend = 8'(a); i2.divisor = 8'(b); end
    endcase
  endtask

  task automatic set_rdy(input int sel, input bit r);
    case (sel)
      0: i0.out_ready = r;
      1: i1.out_ready = r;
      default: i2.out_ready = r;
    endcase
  endtask

  function automatic void obs(input int sel, output bit ir, output bit ovd, output bit bsy,
                              output bit dz, output bit of, output longint q, output longint r);
    case (sel)
      0: begin ir = i0.in_ready; ovd = i0.out_valid; bsy = i0.busy; dz = i0.div_by_zero;
               of = i0.overflow; q = longint'(i0.quotient); r = longint'(i0.remainder); end
      1: begin ir = i1.in_ready; ovd = i1.out_valid; bsy = i1.busy; dz = i1.div_by_zero;
               of = i1.overflow; q = longint'(i1.quotient); r = longint'(i1.remainder); end
      default: begin ir = i2.in_ready; ovd = i2.out_valid; bsy = i2.busy; dz = i2.div_by_zero;
               of = i2.overflow; q = longint'(i2.quotient); r = longint'(i2.remainder); end
    endcase
  endfunction

  // One operation: accept, count cycles to out_valid (junk on inputs meanwhile), hold, handshake
  task automatic run_op(input int sel, input longint a, input longint b, input int hold,
                        output int lat, output longint q, output longint r, output bit dz,
                        output bit of, output bit held_ok, output bit rel_ok);
    bit ir, ovd, bsy, d, o;
    longint qq, rr;
    int t;
    @(negedge clk);
    obs(sel, ir, ovd, bsy, d, o, qq, rr);
    t = 0;
    while (!ir && t < 100) begin
      @(negedge clk);
      obs(sel, ir, ovd, bsy, d, o, qq, rr);
      t++;
    end
    drv(sel, 1'b1, a, b);
    set_rdy(sel, 1'b0);
    @(negedge clk);
    lat = 0;
    obs(sel, ir, ovd, bsy, d, o, qq, rr);
    while (!ovd && lat < 200) begin
      drv(sel, 1'($urandom_range(0, 1)), longint'($urandom), longint'($urandom));
      @(negedge clk);
      lat++;
      obs(sel, ir, ovd, bsy, d, o, qq, rr);
    end
    drv(sel, 1'b0, 0, 0);
    q = qq; r = rr; dz = d; of = o;
    held_ok = ovd && !ir;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      obs(sel, ir, ovd, bsy, d, o, qq, rr);
      if (!ovd || ir || !bsy || qq !== q || rr !== r || d !== dz || o !== of) held_ok = 1'b0;
    end
    set_rdy(sel, 1'b1);
    @(negedge clk);
    set_rdy(sel, 1'b0);
    obs(sel, ir, ovd, bsy, d, o, qq, rr);
    rel_ok = ir && !ovd && !bsy;
  endtask

  task automatic test_reset();
    bit ir, ovd, bsy, d, o;
    longint q, r;
    for (int s = 0; s < 3; s++) begin
      obs(s, ir, ovd, bsy, d, o, q, r);
      n_cmp++;
      if ({ir, ovd, bsy, d, o} !== 5'b10000) begin
        n_bad++;
        $display("FAIL reset_ctrl dut%0d: {in_ready,out_valid,busy,dz,ovf}=%b required 10000",
                 s, {ir, ovd, bsy, d, o});
      end
      n_cmp++;
      if (q !== 0 || r !== 0) begin
        n_bad++;
        $display("FAIL reset_data dut%0d: q=%0d r=%0d required 0 0", s, q, r);
      end
    end
  endtask

  task automatic test_unsigned_basic();
    longint ta[3] = '{9, 6, 8};
    longint tb[3] = '{1, 2, 5};
    longint q, r, eq, er;
    bit dz, of, edz, eof, hk, rk;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(0, ta[i], tb[i], 0, lat, q, r, dz, of, hk, rk);
      model(16, 1'b0, ta[i], tb[i], eq, er, edz, eof);
      n_cmp++;
      if (lat !== 17) begin n_bad++; $display("FAIL u16_latency %0d/%0d: got %0d required 17", ta[i], tb[i], lat); end
      n_cmp++;
      if (q !== eq || r !== er) begin
        n_bad++; $display("FAIL u16_result %0d/%0d: q=%0d r=%0d required q=%0d r=%0d", ta[i], tb[i], q, r, eq, er);
      end
      n_cmp++;
      if ({dz, of} !== {edz, eof}) begin
        n_bad++; $display("FAIL u16_flags %0d/%0d: %b required %b", ta[i], tb[i], {dz, of}, {edz, eof});
      end
    end
  endtask

  task automatic test_signed();
    longint ta[3] = '{-7, 7, -32768};
    longint tb[3] = '{2, -2, -1};
    longint q, r, eq, er;
    bit dz, of, edz, eof, hk, rk;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(1, ta[i], tb[i], 0, lat, q, r, dz, of, hk, rk);
      model(16, 1'b1, ta[i], tb[i], eq, er, edz, eof);
      n_cmp++;
      if (q !== eq || r !== er || lat !== 17) begin
        n_bad++; $display("FAIL s16_result %0d/%0d: q=%h r=%h lat=%0d required q=%h r=%h lat=17",
                          ta[i], tb[i], q, r, lat, eq, er);
      end
      n_cmp++;
      if ({dz, of} !== {edz, eof}) begin
        n_bad++; $display("FAIL s16_flags %0d/%0d: %b required %b", ta[i], tb[i], {dz, of}, {edz, eof});
      end
    end
  endtask

  task automatic test_div_zero();
    int sels[3] = '{0, 1, 1};
    longint ta[3] = '{5, -5, 5};
    longint q, r, eq, er;
    bit dz, of, edz, eof, hk, rk;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(sels[i], ta[i], 0, 0, lat, q, r, dz, of, hk, rk);
      model(16, sels[i] == 1, ta[i], 0, eq, er, edz, eof);
      n_cmp++;
      if (lat !== 1) begin n_bad++; $display("FAIL dz_latency dut%0d %0d/0: got %0d required 1", sels[i], ta[i], lat); end
      n_cmp++;
      if (q !== eq || r !== er || {dz, of} !== {edz, eof}) begin
        n_bad++; $display("FAIL dz_result dut%0d %0d/0: q=%h r=%h f=%b required q=%h r=%h f=%b",
                          sels[i], ta[i], q, r, {dz, of}, eq, er, {edz, eof});
      end
    end
  endtask

  task automatic test_backpressure();
    longint q, r;
    bit dz, of, hk, rk;
    int lat;
    run_op(0, 100, 7, 10, lat, q, r, dz, of, hk, rk);
    n_cmp++;
    if (q !== 14 || r !== 2) begin n_bad++; $display("FAIL bp_result: q=%0d r=%0d required q=14 r=2", q, r); end
    n_cmp++;
    if (hk !== 1'b1) begin n_bad++; $display("FAIL bp_hold: stable/in_ready-low=%b required 1", hk); end
    n_cmp++;
    if (rk !== 1'b1) begin n_bad++; $display("FAIL bp_release: in_ready back after handshake=%b required 1", rk); end
  endtask

  task automatic test_reset_mid();
    bit ir, ovd, bsy, d, o, hk, rk, seen;
    longint q, r;
    int lat;
    @(negedge clk);
    drv(0, 1'b1, 40000, 3);
    @(negedge clk);
    drv(0, 1'b0, 0, 0);
    repeat (4) @(negedge clk);
    obs(0, ir, ovd, bsy, d, o, q, r);
    n_cmp++;
    if (bsy !== 1'b1) begin n_bad++; $display("FAIL rm_busy_before: busy=%b required 1", bsy); end
    rst_n = 1'b0;
    #1;
    obs(0, ir, ovd, bsy, d, o, q, r);
    n_cmp++;
    if ({ir, ovd, bsy} !== 3'b100) begin
      n_bad++; $display("FAIL rm_async: {in_ready,out_valid,busy}=%b required 100", {ir, ovd, bsy});
    end
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      obs(0, ir, ovd, bsy, d, o, q, r);
      if (ovd) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL rm_no_output: out_valid rose=%b required 0", seen); end
    run_op(0, 40000, 3, 0, lat, q, r, d, o, hk, rk);
    n_cmp++;
    if (q !== 13333 || r !== 1 || lat !== 17) begin
      n_bad++; $display("FAIL rm_after: q=%0d r=%0d lat=%0d required q=13333 r=1 lat=17", q, r, lat);
    end
  endtask

  task automatic test_width8();
    longint ta[2] = '{255, 0};
    longint tb[2] = '{16, 9};
    longint q, r, eq, er;
    bit dz, of, edz, eof, hk, rk;
    int lat;
    for (int i = 0; i < 2; i++) begin
      run_op(2, ta[i], tb[i], 0, lat, q, r, dz, of, hk, rk);
      model(8, 1'b0, ta[i], tb[i], eq, er, edz, eof);
      n_cmp++;
      if (lat !== 9) begin n_bad++; $display("FAIL u8_latency %0d/%0d: got %0d required 9", ta[i], tb[i], lat); end
      n_cmp++;
      if (q !== eq || r !== er || {dz, of} !== {edz, eof}) begin
        n_bad++; $display("FAIL u8_result %0d/%0d: q=%0d r=%0d f=%b required q=%0d r=%0d f=%b",
                          ta[i], tb[i], q, r, {dz, of}, eq, er, {edz, eof});
      end
    end
  endtask

  task automatic test_random();
    longint a, b, q, r, eq, er;
    bit dz, of, edz, eof, hk, rk, sgn;
    int lat, sel, w, hold, mode;
    for (int i = 0; i < 60; i++) begin
      sel  = $urandom_range(0, 2);
      w    = (sel == 2) ? 8 : 16;
      sgn  = (sel == 1);
      hold = $urandom_range(0, 3);
      mode = $urandom_range(0, 7);
      a = longint'($urandom);
      b = longint'($urandom);
      if (mode == 0) b = 0;
      else if (mode == 1) begin a = -(longint'(1) << (w - 1)); b = -1; end
      else if (mode == 2) b = 1;
      else if (mode == 3) b = longint'($urandom_range(1, 9));
      run_op(sel, a, b, hold, lat, q, r, dz, of, hk, rk);
      model(w, sgn, a, b, eq, er, edz, eof);
      n_cmp++;
      if (q !== eq || r !== er || {dz, of} !== {edz, eof}) begin
        n_bad++; $display("FAIL rnd_result dut%0d a=%h b=%h: q=%h r=%h f=%b required q=%h r=%h f=%b",
                          sel, a, b, q, r, {dz, of}, eq, er, {edz, eof});
      end
      n_cmp++;
      if (lat !== (edz ? 1 : w + 1)) begin
        n_bad++; $display("FAIL rnd_latency dut%0d: got %0d required %0d", sel, lat, edz ? 1 : w + 1);
      end
      n_cmp++;
      if ({hk, rk} !== 2'b11) begin
        n_bad++; $display("FAIL rnd_handshake dut%0d: hold/release=%b required 11", sel, {hk, rk});
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      drv(s, 1'b0, 0, 0);
      set_rdy(s, 1'b0);
    end
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_width8();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
